set_assoc_cache: RTL
====================

// Module: set_assoc_cache
// PURPOSE
// N-way set-associative, write-through, no-write-allocate cache.
// Successor to direct_cache: adds configurable associativity, per-set round-robin replacement, word writes and a flush.
// Sits between the core load/store port and dram_emulation_mem.
// Refill and write traffic use the same line-wide read bus and handshake style as direct_cache.
// PARAMETERS
// ByteOffsetBits  4   log2(bytes per line); NrWordsPerLine = 2**ByteOffsetBits/4
// IndexBits       6   log2(number of sets)
// TagBits         22  tag width; TagBits+IndexBits+ByteOffsetBits must equal 32
// WayBits         1   log2(ways); NrWays = 2**WayBits, WayBits >= 0
// PORTS
// clk_i             in   1          single clock, all logic on rising edge
// rstn_i            in   1          synchronous, active-low reset
// addr_i            in   32         byte address; [1:0] ignored
// read_en_i         in   1          read request, held until read_valid_o
// write_en_i        in   1          write request, held until write_done_o
// write_data_i      in   32         write word
// flush_i           in   1          invalidate every line
// read_valid_o      out  1          one-cycle pulse, read_word_o valid
// read_word_o       out  32         read data
// write_done_o      out  1          one-cycle pulse, write accepted by memory
// mem_addr_o        out  32         refill: line-aligned addr; write: word-aligned addr
// mem_read_en_o     out  1          refill request, level
// mem_read_valid_i  in   1          refill line valid, one cycle
// mem_read_data_i   in   LineSize   refill line, word 0 in bits [31:0]
// mem_write_en_o    out  1          word write request, level
// mem_write_data_o  out  32         word to write
// mem_write_done_i  in   1          memory write completed, one cycle
// BEHAVIOUR
// Address split: tag = [31 -: TagBits], set = [ByteOffsetBits +: IndexBits], word = [ByteOffsetBits-1:2].
// Reset (rstn_i=0 at an edge):
// - all valid bits and round-robin pointers go to 0; FSM goes to IDLE.
// - every output is 0 from the next cycle.
// - Tag/data arrays are not cleared.
// FSM: IDLE, REFILL, WRITE.
// IDLE arbitration, highest priority first: flush_i, then write_en_i, then read_en_i.
// - A flush takes one cycle and clears all valid bits.
// - The losing request stays pending, because the requester holds it.
// Read hit (tag match on a valid way): read_valid_o=1 with the word on the next cycle. Latency 1. FSM stays in IDLE.
// Read miss: go to REFILL. From the next cycle, mem_read_en_o=1 and mem_addr_o={tag,set,ByteOffsetBits'0}, held until mem_read_valid_i.
// On the mem_read_valid_i edge:
// - Victim = lowest-index invalid way, else rr_ptr[set].
// - Write line and tag into the victim and set its valid bit.
// - If all ways were valid, rr_ptr[set] += 1, mod NrWays.
// - Drop mem_read_en_o, pulse read_valid_o with the requested word from mem_read_data_i next cycle, return to IDLE.
// - Miss latency = DRAM latency + 2.
// Write: go to WRITE. From the next cycle, mem_write_en_o=1, mem_addr_o={addr_i[31:2],2'b0}, mem_write_data_o=write_data_i, held until mem_write_done_i.
// - On a hit, the cached word is updated on the same edge as the entry to WRITE. Hit detection happens in IDLE.
// - On a miss, nothing is allocated and replacement state is untouched.
// - When mem_write_done_i is sampled: drop mem_write_en_o, pulse write_done_o next cycle, return to IDLE.
// A request still asserted on the cycle after read_valid_o/write_done_o is treated as a new request.
// The requester must change or drop it if no repeat is intended.
// flush_i outside IDLE is ignored. mem_read_valid_i/mem_write_done_i outside REFILL/WRITE are ignored.
// Reset during REFILL/WRITE: the transaction is abandoned and no line is written. A late mem_read_valid_i is ignored.
// TESTING
// Setup: the bench uses ByteOffsetBits=4, IndexBits=6, TagBits=22, WayBits=1, with a 10-cycle dram_emulation_mem.
// 1. Read 0x414 after reset -> mem_read_en_o, mem_addr_o=0x410; read_valid_o, word 1 of line. Re-read 0x414 -> read_valid_o 1 cycle later, no mem_read_en_o.
// 2. Read 0x410, 0x810, 0xC10 (all set 1) -> 3 refills, 0xC10 evicts way0. Then 0x810 hits; 0x410 misses, refill evicts way1.
// 3. Write 0x418=0xDEADBEEF after 0x410 is cached -> mem_write_en_o with addr 0x418; write_done_o after mem_write_done_i. Read 0x418 -> 0xDEADBEEF, no refill.
// 4. Write 0x1000 when uncached -> memory write only. Read 0x1000 then misses and refills from 0x1000.
// 5. Reset 3 cycles into the refill of 0x424 -> all outputs 0 the next cycle. Re-read 0x424 -> full miss, correct word.
// 6. Cache 0x414, pulse flush_i in IDLE -> read 0x414 misses. flush_i during REFILL -> no effect, refill completes.

Source files
------------

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative, write-through, no-write-allocate cache.
// Hits are answered from the local arrays one cycle after the request. Misses
// refill a whole line over the line-wide memory read bus. Every store is
// forwarded to memory as a single word write; a store that hits also patches
// the cached copy so later reads see the new word without a refill.
// Replacement picks the lowest-index invalid way, otherwise a per-set
// round-robin pointer. A flush invalidates every line in a single cycle.
// ByteOffsetBits must be at least 3 so that a line holds two or more words.

module set_assoc_cache #(
  parameter int ByteOffsetBits = 4,
  parameter int IndexBits      = 6,
  parameter int TagBits        = 22,
  parameter int WayBits        = 1,
  localparam int LineSize      = 8 * (2 ** ByteOffsetBits)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [31:0]         addr_i,
  input  logic                read_en_i,
  input  logic                write_en_i,
  input  logic [31:0]         write_data_i,
  input  logic                flush_i,
  output logic                read_valid_o,
  output logic [31:0]         read_word_o,
  output logic                write_done_o,
  output logic [31:0]         mem_addr_o,
  output logic                mem_read_en_o,
  input  logic                mem_read_valid_i,
  input  logic [LineSize-1:0] mem_read_data_i,
  output logic                mem_write_en_o,
  output logic [31:0]         mem_write_data_o,
  input  logic                mem_write_done_i
);

  localparam int NrWays         = 2 ** WayBits;
  localparam int NrSets         = 2 ** IndexBits;
  localparam int NrWordsPerLine = (2 ** ByteOffsetBits) / 4;
  localparam int WordBits       = ByteOffsetBits - 2;
  // Way indices need at least one bit even for a direct-mapped build.
  localparam int WayW           = (WayBits > 0) ? WayBits : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_WRITE
  } state_t;

  // ---------------------------------------------------------------------
  // Address decomposition of the incoming request
  // ---------------------------------------------------------------------
  logic [TagBits-1:0]   w_tag;
  logic [IndexBits-1:0] w_set;
  logic [WordBits-1:0]  w_word;
  logic                 w_unused_addr;

  assign w_tag  = addr_i[31 -: TagBits];
  assign w_set  = addr_i[ByteOffsetBits +: IndexBits];
  assign w_word = addr_i[ByteOffsetBits-1:2];
  // The byte lane bits carry no meaning for word accesses.
  assign w_unused_addr = &{1'b0, addr_i[1:0]};

  // ---------------------------------------------------------------------
  // Storage. Tags and lines are plain arrays without reset; only the valid
  // bits and replacement pointers are cleared by reset or flush.
  // ---------------------------------------------------------------------
  logic [TagBits-1:0]  r_tag_mem  [NrWays][NrSets];
  logic [LineSize-1:0] r_data_mem [NrWays][NrSets];

  logic [NrSets-1:0][NrWays-1:0] r_valid;
  logic [NrSets-1:0][WayW-1:0]   r_rr;

  state_t               r_state;
  logic [TagBits-1:0]   r_req_tag;
  logic [IndexBits-1:0] r_req_set;
  logic [WordBits-1:0]  r_req_word;

  // ---------------------------------------------------------------------
  // Hit detection, one comparator per way
  // ---------------------------------------------------------------------
  logic [NrWays-1:0] w_way_hit;
  logic              w_hit;
  logic [WayW-1:0]   w_hit_way;
  logic [LineSize-1:0] w_hit_line;
  logic [31:0]       w_hit_word;

  generate
    for (genvar gi = 0; gi < NrWays; gi++) begin : g_way_cmp
      assign w_way_hit[gi] = r_valid[w_set][gi] && (r_tag_mem[gi][w_set] == w_tag);
    end
  endgenerate

  assign w_hit = |w_way_hit;

  // Encode the matching way; at most one way can match a given tag.
  always_comb begin
    w_hit_way = '0;
    for (int i = NrWays - 1; i >= 0; i--) begin
      if (w_way_hit[i]) begin
        w_hit_way = WayW'(i);
      end
    end
  end

  assign w_hit_line = r_data_mem[w_hit_way][w_set];
  assign w_hit_word = w_hit_line[{w_word, 5'd0} +: 32];

  // ---------------------------------------------------------------------
  // Victim selection for the set being refilled
  // ---------------------------------------------------------------------
  logic [NrWays-1:0] w_set_valid;
  logic              w_all_valid;
  logic [WayW-1:0]   w_victim;
  logic [WayW-1:0]   w_rr_next;

  assign w_set_valid = r_valid[r_req_set];
  assign w_all_valid = &w_set_valid;

  // Lowest-index invalid way wins; a full set falls back to round-robin.
  always_comb begin
    w_victim = r_rr[r_req_set];
    for (int i = NrWays - 1; i >= 0; i--) begin
      if (!w_set_valid[i]) begin
        w_victim = WayW'(i);
      end
    end
  end

  generate
    if (NrWays > 1) begin : g_rr_wrap
      // NrWays is a power of two, so the natural wrap is the modulo.
      assign w_rr_next = r_rr[r_req_set] + WayW'(1);
    end else begin : g_rr_single
      assign w_rr_next = '0;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Array write enables. Both are gated by reset so an abandoned refill or
  // a store coinciding with reset never lands in the arrays.
  // ---------------------------------------------------------------------
  logic w_refill_we;
  logic w_wr_hit_we;

  assign w_refill_we = rstn_i && (r_state == S_REFILL) && mem_read_valid_i;
  assign w_wr_hit_we = rstn_i && (r_state == S_IDLE) && !flush_i && write_en_i && w_hit;

  // Tag/line array updates: whole-line refill or a single-word store hit.
  always_ff @(posedge clk_i) begin
    if (w_refill_we) begin
      r_tag_mem[w_victim][r_req_set]  <= r_req_tag;
      r_data_mem[w_victim][r_req_set] <= mem_read_data_i;
    end else if (w_wr_hit_we) begin
      r_data_mem[w_hit_way][w_set][{w_word, 5'd0} +: 32] <= write_data_i;
    end
  end

  // Control FSM with registered outputs, valid bits and replacement state.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state          <= S_IDLE;
      r_valid          <= '0;
      r_rr             <= '0;
      r_req_tag        <= '0;
      r_req_set        <= '0;
      r_req_word       <= '0;
      read_valid_o     <= 1'b0;
      read_word_o      <= '0;
      write_done_o     <= 1'b0;
      mem_addr_o       <= '0;
      mem_read_en_o    <= 1'b0;
      mem_write_en_o   <= 1'b0;
      mem_write_data_o <= '0;
    end else begin
      read_valid_o <= 1'b0;
      write_done_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush_i) begin
            r_valid <= '0;
          end else if (write_en_i) begin
            // The cached word (if any) is patched by the array process.
            mem_write_en_o   <= 1'b1;
            mem_addr_o       <= {addr_i[31:2], 2'b00};
            mem_write_data_o <= write_data_i;
            r_state          <= S_WRITE;
          end else if (read_en_i) begin
            if (w_hit) begin
              read_valid_o <= 1'b1;
              read_word_o  <= w_hit_word;
            end else begin
              mem_read_en_o <= 1'b1;
              mem_addr_o    <= {w_tag, w_set, {ByteOffsetBits{1'b0}}};
              r_req_tag     <= w_tag;
              r_req_set     <= w_set;
              r_req_word    <= w_word;
              r_state       <= S_REFILL;
            end
          end
        end

        S_REFILL: begin
          if (mem_read_valid_i) begin
            r_valid[r_req_set][w_victim] <= 1'b1;
            if (w_all_valid) begin
              r_rr[r_req_set] <= w_rr_next;
            end
            mem_read_en_o <= 1'b0;
            read_valid_o  <= 1'b1;
            read_word_o   <= mem_read_data_i[{r_req_word, 5'd0} +: 32];
            r_state       <= S_IDLE;
          end
        end

        S_WRITE: begin
          if (mem_write_done_i) begin
            mem_write_en_o <= 1'b0;
            write_done_o   <= 1'b1;
            r_state        <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
